// File: rtl/des_pkg.sv
// DES key-schedule constants: permutation tables, shift schedule, FSM state type.
package des_pkg;

    localparam int KEY_W    = 64;
    localparam int CD_W     = 28;
    localparam int SUBKEY_W = 48;

    // PC-1: entry i gives the DES key bit (1 = MSB) feeding output bit i+1.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: entry j gives the {C,D} bit (1 = MSB) feeding subkey bit j+1.
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Left-rotation amount for rounds 1..16 (index 0 = round 1); sums to 28.
    localparam logic [1:0] SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic [CD_W-1:0] rotl(input logic [CD_W-1:0] v, input logic [1:0] n);
        case (n)
            2'd1:    rotl = {v[CD_W-2:0], v[CD_W-1]};
            2'd2:    rotl = {v[CD_W-3:0], v[CD_W-1:CD_W-2]};
            default: rotl = v;
        endcase
    endfunction

    function automatic logic [CD_W-1:0] rotr(input logic [CD_W-1:0] v, input logic [1:0] n);
        case (n)
            2'd1:    rotr = {v[0], v[CD_W-1:1]};
            2'd2:    rotr = {v[1:0], v[CD_W-1:2]};
            default: rotr = v;
        endcase
    endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression permutation: 56-bit {C,D} to 48-bit round subkey, pure wiring.
module des_pc2
    import des_pkg::*;
(
    input  logic [2*CD_W-1:0]   cd,
    output logic [SUBKEY_W-1:0] subkey
);

    // Bit 1 in DES numbering is the MSB on both sides.
    for (genvar j = 0; j < SUBKEY_W; j++) begin : g_bit
        assign subkey[SUBKEY_W-1-j] = cd[2*CD_W-PC2[j]];
    end

endmodule

// File: rtl/des_key_scheduler.sv
// DES key scheduler: issues the 16 round subkeys in encrypt or decrypt order
// under a valid/ready handshake, one subkey per accepted round.
module des_key_scheduler
    import des_pkg::*;
#(
    parameter bit ZERO_IDLE_OUT = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                decrypt,
    input  logic [KEY_W-1:0]    key,
    input  logic                subkey_ready,
    output logic [SUBKEY_W-1:0] subkey,
    output logic                subkey_valid,
    output logic [3:0]          round_idx,
    output logic                busy,
    output logic                done
);

    state_t              state_q, state_d;
    logic [CD_W-1:0]     c_q, d_q;
    logic [3:0]          round_q;
    logic                dec_q;
    logic [2*CD_W-1:0]   pc1_key;
    logic [SUBKEY_W-1:0] pc2_out;
    logic [1:0]          shamt;
    logic                start_ok;
    logic                hs;

    // PC-1 drops the parity bits and reorders into {C,D}.
    for (genvar i = 0; i < 2*CD_W; i++) begin : g_pc1
        assign pc1_key[2*CD_W-1-i] = key[KEY_W-PC1[i]];
    end

    des_pc2 u_pc2 (
        .cd     ({c_q, d_q}),
        .subkey (pc2_out)
    );

    assign start_ok = (state_q == ST_IDLE) && start;
    assign hs       = subkey_valid && subkey_ready;

    // Rotation applied on a handshake. Encrypt moves to the next round's
    // left shift (none after the last round); decrypt undoes the shift of the
    // round just issued, which walks the table backwards (index 15 - round).
    always_comb begin
        shamt = 2'd0;
        if (dec_q)
            shamt = SHIFT[~round_q];
        else if (round_q != 4'd15)
            shamt = SHIFT[round_q + 4'd1];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)                   state_d = ST_ROUND;
            ST_ROUND: if (hs && round_q == 4'd15)  state_d = ST_DONE;
            ST_DONE:                               state_d = ST_IDLE;
            default:                               state_d = ST_IDLE;
        endcase
    end

    // C/D registers and round counter; load on start, step on handshake.
    // The counter wraps 15 -> 0 naturally as the last round is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            dec_q   <= 1'b0;
        end else if (start_ok) begin
            c_q     <= decrypt ? pc1_key[2*CD_W-1:CD_W] : rotl(pc1_key[2*CD_W-1:CD_W], 2'd1);
            d_q     <= decrypt ? pc1_key[CD_W-1:0]      : rotl(pc1_key[CD_W-1:0], 2'd1);
            round_q <= '0;
            dec_q   <= decrypt;
        end else if (hs) begin
            c_q     <= dec_q ? rotr(c_q, shamt) : rotl(c_q, shamt);
            d_q     <= dec_q ? rotr(d_q, shamt) : rotl(d_q, shamt);
            round_q <= round_q + 4'd1;
        end
    end

    // Outputs decoded straight from state; subkey is combinational from C/D.
    always_comb begin
        subkey_valid = (state_q == ST_ROUND);
        busy         = (state_q != ST_IDLE);
        done         = (state_q == ST_DONE);
        round_idx    = round_q;
        subkey       = (ZERO_IDLE_OUT && !subkey_valid) ? '0 : pc2_out;
    end

endmodule

// File: tb/tb_des_key_scheduler.sv
// Directed bench for des_key_scheduler using the classic 133457799BBCDFF1 key.
module tb_des_key_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        decrypt;
    logic [63:0] key;
    logic        subkey_ready;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [63:0] KEY0 = 64'h133457799BBCDFF1;

    // Hand-derived K1..K16 for KEY0.
    logic [47:0] kref [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    des_key_scheduler #(.ZERO_IDLE_OUT(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .decrypt      (decrypt),
        .key          (key),
        .subkey_ready (subkey_ready),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .round_idx    (round_idx),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"},  64'(subkey_valid), 64'd0);
        chk({tag, ".busy"},   64'(busy),         64'd0);
        chk({tag, ".done"},   64'(done),         64'd0);
        chk({tag, ".round"},  64'(round_idx),    64'd0);
        chk({tag, ".subkey"}, 64'(subkey),       64'd0);
    endtask

    // Present start for one cycle; returns at the first valid cycle.
    task automatic kick(input logic [63:0] k, input logic dec);
        key = k; decrypt = dec; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Check rounds r0..15 starting at the current negedge; optional stall
    // and mid-run disturbance. Returns at the done cycle.
    task automatic run_rounds(input logic dec, input int r0, input int stall_at, input int poke_at);
        for (int r = r0; r < 16; r++) begin
            chk($sformatf("r%0d.valid", r), 64'(subkey_valid), 64'd1);
            chk($sformatf("r%0d.idx", r),   64'(round_idx),    64'(r));
            chk($sformatf("r%0d.key", r),   64'(subkey),       64'(dec ? kref[15-r] : kref[r]));
            chk($sformatf("r%0d.busy", r),  64'(busy),         64'd1);
            if (r == stall_at) begin
                subkey_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk($sformatf("stall%0d.idx", s), 64'(round_idx), 64'(r));
                    chk($sformatf("stall%0d.key", s), 64'(subkey),    64'(dec ? kref[15-r] : kref[r]));
                end
                subkey_ready = 1'b1;
            end
            if (r == poke_at) begin
                start = 1'b1; key = 64'hFFEEDDCCBBAA9988; decrypt = ~dec;
            end
            @(negedge clk);
            start = 1'b0;
        end
        chk("done.pulse", 64'(done),         64'd1);
        chk("done.busy",  64'(busy),         64'd1);
        chk("done.valid", 64'(subkey_valid), 64'd0);
        chk("done.round", 64'(round_idx),    64'd0);
        chk("done.key",   64'(subkey),       64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; decrypt = 1'b0; key = '0; subkey_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        // Plain encrypt; first valid one cycle after start, done 17 cycles after.
        kick(KEY0, 1'b0);
        run_rounds(1'b0, 0, -1, -1);
        @(negedge clk);
        chk_idle("enc.after");

        // Decrypt order is the reverse.
        kick(KEY0, 1'b1);
        run_rounds(1'b1, 0, -1, -1);
        @(negedge clk);
        chk_idle("dec.after");

        // Stall five cycles at round 7.
        kick(KEY0, 1'b0);
        run_rounds(1'b0, 0, 7, -1);
        @(negedge clk);

        // Start/key/decrypt poked during round 3 are ignored.
        kick(KEY0, 1'b0);
        run_rounds(1'b0, 0, -1, 3);
        @(negedge clk);

        // Reset at round 10 with a live handshake.
        kick(KEY0, 1'b0);
        for (int r = 0; r < 10; r++) @(negedge clk);
        chk("pre_rst.idx", 64'(round_idx), 64'd10);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("mid_rst");
        rst = 1'b0;
        @(negedge clk);
        chk_idle("mid_rst.idle");
        kick(KEY0, 1'b0);
        chk("restart.key", 64'(subkey), 64'(kref[0]));
        run_rounds(1'b0, 0, -1, -1);

        // Back-to-back: start in the idle cycle right after done.
        @(negedge clk);
        chk("gap.busy", 64'(busy), 64'd0);
        kick(KEY0, 1'b1);
        chk("b2b.busy", 64'(busy), 64'd1);
        run_rounds(1'b1, 0, -1, -1);
        @(negedge clk);
        chk_idle("end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/des_key_scheduler.md
DES_KEY_SCHEDULER -- requirements
Module: des_key_scheduler

Interface
REQ-001 Parameter: ZERO_IDLE_OUT, default 1, meaning: when 1, subkey is forced to 48'h0 whenever subkey_valid is low.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin a 16-round key schedule; sampled only in IDLE.
REQ-005 decrypt  input  1  sampled with start; 0 = K1..K16 order, 1 = K16..K1 order.
REQ-006 key  input  64  DES key, bit 63 = DES bit 1; sampled with start; parity bits ignored.
REQ-007 subkey_ready  input  1  consumer (round datapath) accepts the current subkey.
REQ-008 subkey  output  48  current round subkey, bit 47 = PC-2 output bit 1.
REQ-009 subkey_valid  output  1  subkey is valid for round round_idx.
REQ-010 round_idx  output  4  0..15 = round currently presented, in issue order.
REQ-011 busy  output  1  high from start acceptance until the done cycle, inclusive.
REQ-012 done  output  1  one-cycle pulse after round 16 is accepted.

Function
REQ-013 FSM states: IDLE, ROUND, DONE.
- IDLE: start=1 -> ROUND.
- ROUND: the handshake for round 15 -> DONE.
- DONE -> IDLE unconditionally.
REQ-014 On start acceptance in IDLE, C/D registers load PC-1(key); encrypt pre-rotates left by 1; decrypt applies no rotation.
REQ-015 subkey_valid is high exactly while in ROUND; the first subkey is presented the cycle after start is accepted (latency 1).
REQ-016 subkey = PC-2({C,D}), combinational from the C/D registers; no output register.
REQ-017 A handshake is subkey_valid && subkey_ready.
- C, D, subkey and round_idx hold while subkey_ready is low, for any number of cycles.
REQ-018 On a handshake, round_idx increments and C/D rotate for the next round.
- Encrypt: rotate left by SHIFT[n], where n is the next round number 1..16.
- Decrypt: rotate right by SHIFT[17-n], where n is the issue position just accepted.
REQ-019 SHIFT schedule = 1 for rounds 1, 2, 9, 16 and 2 for all other rounds; cumulative rotation is 28, so C/D return to PC-1 values after round 16.
REQ-020 start, decrypt and key are ignored while busy; key/decrypt changes mid-operation have no effect.
REQ-021 done asserts in the DONE state only.
- busy stays high in DONE and drops to 0 in the following IDLE cycle.
- A start in that IDLE cycle is accepted (back-to-back schedules, one idle gap).
REQ-022 round_idx wraps to 0 on entry to DONE; it never exceeds 15.

Reset
REQ-023 rst has priority over all inputs and returns the FSM to IDLE from any state, including mid-schedule.
REQ-024 Reset values: subkey_valid=0, busy=0, done=0, round_idx=0, C=D=0, subkey=0.
REQ-025 Reset during a handshake cycle discards that handshake; the next start restarts from round 1.

Structure
REQ-026 Shared package des_pkg holds:
- PC1 and PC2 tables as constant arrays;
- the SHIFT schedule constant;
- a state enum type;
- width constants (KEY_W=64, CD_W=28, SUBKEY_W=48).
REQ-027 The tables are compile-time constants, not runtime file loads; no initial blocks in synthesizable logic.
REQ-028 One combinational sub-module des_pc2 (56-bit in, 48-bit out) implements PC-2; PC-1 and the rotations are inline.

Verification
REQ-029 key=64'h133457799BBCDFF1, decrypt=0, subkey_ready=1 -> subkey 48'h1B02EFFC7072 at round_idx 0, first valid the cycle after start; 48'hCB3D8B0E17F5 at round_idx 15; done 17 cycles after start.
REQ-030 Same key, decrypt=1 -> first subkey 48'hCB3D8B0E17F5, last subkey 48'h1B02EFFC7072; all 16 subkeys equal the encrypt sequence reversed.
REQ-031 Deassert subkey_ready for 5 cycles at round_idx 7 -> subkey and round_idx stable throughout; the sequence resumes with no skip or duplicate.
REQ-032 Pulse start and change key during round 3 -> no effect; output matches the uninterrupted schedule.
REQ-033 Assert rst at round_idx 10 -> next cycle all outputs 0 and FSM in IDLE; a new start then yields K1 again.
REQ-034 Start in the IDLE cycle immediately after done -> second schedule correct; busy low for exactly one cycle between schedules.
